// File: rtl/eth_tx_sched_if.sv
// rtl/eth_tx_sched_if.sv - transmit bus between the scheduler and eth_mac
//
// Signals:
//   tx_go      frame start pulse to the MAC
//   data_len   latched frame length for the MAC
//   len_type   latched length/type field for the MAC
//   des_mac    latched destination MAC address for the MAC
//   fifo_rq    nibble request from the MAC
//   fifo_da    nibble returned to the MAC
//   mac_tx_en  MAC frame-activity indicator (mii_tx_en)
// Modports: master = scheduler side, slave = MAC side.

interface eth_tx_sched_if;
  logic        tx_go;
  logic [10:0] data_len;
  logic [15:0] len_type;
  logic [47:0] des_mac;
  logic        fifo_rq;
  logic [3:0]  fifo_da;
  logic        mac_tx_en;

  modport master (
    output tx_go, data_len, len_type, des_mac, fifo_da,
    input  fifo_rq, mac_tx_en
  );

  modport slave (
    input  tx_go, data_len, len_type, des_mac, fifo_da,
    output fifo_rq, mac_tx_en
  );
endinterface

// File: rtl/eth_tx_sched.sv
// rtl/eth_tx_sched.sv - round-robin transmit scheduler for two frame sources sharing eth_mac
//
// Ports:
//   mii_tx_clk        transmit clock from the PHY
//   rst_n             asynchronous active-low reset
//   req0/req1         level frame request per source
//   len0/len1         frame length per source
//   type0/type1       length/type field per source
//   dmac0/dmac1       destination MAC per source
//   da0/da1           payload nibble per source
//   grant0/grant1     one-cycle grant pulse to the winning source
//   rd0/rd1           nibble read strobe routed to the owning source
//   busy              high whenever the scheduler is not idle
//   to_err            one-cycle pulse when the MAC never starts the frame
//   frame_cnt         completed frame count, wrapping
//   mac               MAC-side bus (tx_go, parameters, fifo_rq/fifo_da, mac_tx_en)

module eth_tx_sched #(
  parameter int IFG_CYC  = 24,
  parameter int START_TO = 64
) (
  input  logic                  mii_tx_clk,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic                  req1,
  input  logic [10:0]           len0,
  input  logic [10:0]           len1,
  input  logic [15:0]           type0,
  input  logic [15:0]           type1,
  input  logic [47:0]           dmac0,
  input  logic [47:0]           dmac1,
  input  logic [3:0]            da0,
  input  logic [3:0]            da1,
  output logic                  grant0,
  output logic                  grant1,
  output logic                  rd0,
  output logic                  rd1,
  output logic                  busy,
  output logic                  to_err,
  output logic [15:0]           frame_cnt,
  eth_tx_sched_if.master        mac
);

  localparam int TMR_MAX = (START_TO > IFG_CYC) ? START_TO : IFG_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX) + 1;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    GO         = 3'd1,
    WAIT_START = 3'd2,
    SEND       = 3'd3,
    WAIT_END   = 3'd4,
    IFG        = 3'd5
  } state_t;

  state_t           state;
  logic             owner;
  logic             last_owner;
  logic             mac_en_q;
  logic [TMR_W-1:0] tmr;
  logic             winner;
  logic             route;

  // A sole requester wins outright; on a tie the port that did not go last wins.
  always_comb begin
    winner = (req0 && req1) ? ~last_owner : req1;
  end

  always_ff @(posedge mii_tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      owner        <= 1'b0;
      last_owner   <= 1'b1;
      mac_en_q     <= 1'b0;
      tmr          <= '0;
      grant0       <= 1'b0;
      grant1       <= 1'b0;
      busy         <= 1'b0;
      to_err       <= 1'b0;
      frame_cnt    <= 16'h0000;
      mac.tx_go    <= 1'b0;
      mac.data_len <= 11'd0;
      mac.len_type <= 16'h0000;
      mac.des_mac  <= 48'h0;
    end else begin
      mac_en_q  <= mac.mac_tx_en;
      mac.tx_go <= 1'b0;
      grant0    <= 1'b0;
      grant1    <= 1'b0;
      to_err    <= 1'b0;

      case (state)
        IDLE: begin
          if (req0 || req1) begin
            // Everything the GO cycle presents is loaded on this edge so the
            // MAC sees tx_go and stable parameters together.
            state        <= GO;
            busy         <= 1'b1;
            mac.tx_go    <= 1'b1;
            grant0       <= ~winner;
            grant1       <= winner;
            owner        <= winner;
            last_owner   <= winner;
            mac.data_len <= winner ? len1  : len0;
            mac.len_type <= winner ? type1 : type0;
            mac.des_mac  <= winner ? dmac1 : dmac0;
          end
        end

        GO: begin
          tmr   <= '0;
          state <= WAIT_START;
        end

        WAIT_START: begin
          tmr <= tmr + TMR_W'(1);
          if (mac.mac_tx_en) begin
            state <= SEND;
          end else if (tmr == TMR_W'(START_TO - 1)) begin
            to_err <= 1'b1;
            busy   <= 1'b0;
            state  <= IDLE;
          end
        end

        SEND: begin
          // End of frame is the falling edge of the MAC's activity flag.
          if (mac_en_q && !mac.mac_tx_en) begin
            frame_cnt <= frame_cnt + 16'd1;
            tmr       <= '0;
            state     <= IFG;
          end
        end

        IFG: begin
          if (tmr == TMR_W'(IFG_CYC - 1)) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            tmr <= tmr + TMR_W'(1);
          end
        end

        // WAIT_END and the unused encodings recover to IDLE.
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Read strobe and nibble path are combinational so the MAC's request is
  // answered in the same cycle; only the owning source sees a strobe.
  always_comb begin
    route       = (state == WAIT_START) || (state == SEND);
    rd0         = route && mac.fifo_rq && !owner;
    rd1         = route && mac.fifo_rq && owner;
    mac.fifo_da = route ? (owner ? da1 : da0) : 4'h0;
  end

endmodule

// File: tb/tb_eth_tx_sched.sv
// tb/tb_eth_tx_sched.sv - self-checking bench for eth_tx_sched
//
// Drives both frame sources and plays the eth_mac role on the MAC-side bus.
// Expected arbitration, frame count and routing come from a small model of
// the scheduling rules kept in this file.

module tb_eth_tx_sched;

  localparam int IFG_CYC  = 24;
  localparam int START_TO = 64;

  logic        mii_tx_clk;
  logic        rst_n;
  logic        req0, req1;
  logic [10:0] len0, len1;
  logic [15:0] type0, type1;
  logic [47:0] dmac0, dmac1;
  logic [3:0]  da0, da1;
  logic        grant0, grant1, rd0, rd1, busy, to_err;
  logic [15:0] frame_cnt;

  eth_tx_sched_if mac_bus ();

  eth_tx_sched #(.IFG_CYC(IFG_CYC), .START_TO(START_TO)) dut (
    .mii_tx_clk (mii_tx_clk),
    .rst_n      (rst_n),
    .req0       (req0),
    .req1       (req1),
    .len0       (len0),
    .len1       (len1),
    .type0      (type0),
    .type1      (type1),
    .dmac0      (dmac0),
    .dmac1      (dmac1),
    .da0        (da0),
    .da1        (da1),
    .grant0     (grant0),
    .grant1     (grant1),
    .rd0        (rd0),
    .rd1        (rd1),
    .busy       (busy),
    .to_err     (to_err),
    .frame_cnt  (frame_cnt),
    .mac        (mac_bus)
  );

  initial mii_tx_clk = 1'b0;
  always #20 mii_tx_clk = ~mii_tx_clk;

  int          tests = 0;
  int          fails = 0;
  bit          m_last = 1'b1;
  logic [15:0] m_cnt  = 16'h0000;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge mii_tx_clk);
    #1;
  endtask

  task automatic sample();
    @(negedge mii_tx_clk);
  endtask

  task automatic check_route(input string tag, input bit act, input bit own);
    check({tag, "_rd0"}, rd0, act && mac_bus.fifo_rq && !own);
    check({tag, "_rd1"}, rd1, act && mac_bus.fifo_rq && own);
    check({tag, "_da"}, mac_bus.fifo_da, act ? (own ? da1 : da0) : 4'h0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_tx_go"}, mac_bus.tx_go, 0);
    check({tag, "_grant0"}, grant0, 0);
    check({tag, "_grant1"}, grant1, 0);
    check({tag, "_rd0"}, rd0, 0);
    check({tag, "_rd1"}, rd1, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_to_err"}, to_err, 0);
    check({tag, "_fifo_da"}, mac_bus.fifo_da, 0);
    check({tag, "_data_len"}, mac_bus.data_len, 0);
    check({tag, "_len_type"}, mac_bus.len_type, 0);
    check({tag, "_des_mac"}, mac_bus.des_mac, 0);
    check({tag, "_frame_cnt"}, frame_cnt, 0);
  endtask

  task automatic rand_params();
    len0  = 11'($urandom);
    len1  = 11'($urandom);
    type0 = 16'($urandom);
    type1 = 16'($urandom);
    dmac0 = 48'({$urandom, $urandom});
    dmac1 = 48'({$urandom, $urandom});
    da0   = 4'($urandom);
    da1   = 4'($urandom);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      mac_bus.fifo_rq = 1'($urandom);
      sample();
      check("idle_busy", busy, 0);
      check("idle_tx_go", mac_bus.tx_go, 0);
      check_route("idle", 1'b0, 1'b0);
    end
  endtask

  task automatic reset_pulse();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n  = 1'b1;
    m_cnt  = 16'h0000;
    m_last = 1'b1;
  endtask

  // One frame from an IDLE cycle through the end of the inter-frame gap.
  // pre: cycles from tx_go until mac_tx_en rises; act: cycles mac_tx_en is high;
  // abort_at: active cycle at which reset is pulsed (-1 for none).
  task automatic do_frame(input bit r0, input bit r1, input bit hold,
                          input int pre, input int act, input int abort_at);
    bit          w;
    logic [10:0] el;
    logic [15:0] et;
    logic [47:0] ed;
    tick();
    req0 = r0;
    req1 = r1;
    w  = (r0 && r1) ? !m_last : r1;
    el = w ? len1 : len0;
    et = w ? type1 : type0;
    ed = w ? dmac1 : dmac0;
    mac_bus.fifo_rq = 1'b0;
    sample();
    check("req_busy", busy, 0);
    check("req_tx_go", mac_bus.tx_go, 0);
    tick();
    if (!hold) begin
      req0 = 1'b0;
      req1 = 1'b0;
    end
    sample();
    check("go_tx_go", mac_bus.tx_go, 1);
    check("go_grant0", grant0, !w);
    check("go_grant1", grant1, w);
    check("go_data_len", mac_bus.data_len, el);
    check("go_len_type", mac_bus.len_type, et);
    check("go_des_mac", mac_bus.des_mac, ed);
    check("go_busy", busy, 1);
    m_last = w;
    for (int i = 1; i <= pre; i++) begin
      tick();
      mac_bus.fifo_rq = 1'($urandom);
      if (i == pre) mac_bus.mac_tx_en = 1'b1;
      sample();
      check("ws_tx_go", mac_bus.tx_go, 0);
      check("ws_grant", {grant0, grant1}, 0);
      check_route("ws", 1'b1, w);
    end
    for (int i = 1; i < act; i++) begin
      tick();
      mac_bus.fifo_rq = 1'($urandom);
      if (i == abort_at) begin
        mac_bus.fifo_rq = 1'b1;
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_mid");
        tick();
        rst_n = 1'b1;
        mac_bus.mac_tx_en = 1'b0;
        mac_bus.fifo_rq = 1'b0;
        m_cnt  = 16'h0000;
        m_last = 1'b1;
        sample();
        check("rst_after_busy", busy, 0);
        check("rst_after_cnt", frame_cnt, 0);
        return;
      end
      sample();
      check("send_busy", busy, 1);
      check("send_cnt", frame_cnt, m_cnt);
      check_route("send", 1'b1, w);
    end
    tick();
    mac_bus.mac_tx_en = 1'b0;
    mac_bus.fifo_rq = 1'($urandom);
    sample();
    check_route("fall", 1'b1, w);
    check("fall_cnt", frame_cnt, m_cnt);
    m_cnt = m_cnt + 16'd1;
    for (int j = 1; j <= IFG_CYC; j++) begin
      tick();
      mac_bus.fifo_rq = 1'($urandom);
      sample();
      check("ifg_busy", busy, 1);
      check("ifg_tx_go", mac_bus.tx_go, 0);
      check("ifg_to_err", to_err, 0);
      check("ifg_cnt", frame_cnt, m_cnt);
      check_route("ifg", 1'b0, w);
    end
  endtask

  task automatic do_timeout();
    tick();
    req0 = 1'b1;
    req1 = 1'b0;
    sample();
    check("to_req_tx_go", mac_bus.tx_go, 0);
    tick();
    req0 = 1'b0;
    sample();
    check("to_go_tx_go", mac_bus.tx_go, 1);
    check("to_go_grant0", grant0, 1);
    m_last = 1'b0;
    for (int i = 1; i <= START_TO; i++) begin
      tick();
      mac_bus.fifo_rq = 1'($urandom);
      sample();
      check("to_wait_err", to_err, 0);
      check("to_wait_busy", busy, 1);
      check_route("to_wait", 1'b1, 1'b0);
    end
    tick();
    sample();
    check("to_err_pulse", to_err, 1);
    check("to_err_busy", busy, 0);
    check("to_err_cnt", frame_cnt, m_cnt);
    check_route("to_idle", 1'b0, 1'b0);
    tick();
    sample();
    check("to_err_clear", to_err, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    req0 = 1'b0;
    req1 = 1'b0;
    len0 = '0; len1 = '0; type0 = '0; type1 = '0;
    dmac0 = '0; dmac1 = '0; da0 = '0; da1 = '0;
    mac_bus.fifo_rq = 1'b0;
    mac_bus.mac_tx_en = 1'b0;

    // Reset state
    repeat (3) @(posedge mii_tx_clk);
    sample();
    check_all_zero("reset");
    tick();
    rst_n = 1'b1;
    sample();
    check_all_zero("post_reset");

    // Single request from port 1 with fixed parameters
    rand_params();
    len1  = 11'd105;
    type1 = 16'h0806;
    dmac1 = 48'hFFFFFFFFFFFF;
    do_frame(1'b0, 1'b1, 1'b0, 3, 150, -1);
    check("single_cnt", frame_cnt, 1);

    // Tie from reset with both requests held
    reset_pulse();
    for (int k = 0; k < 4; k++) begin
      rand_params();
      do_frame(1'b1, 1'b1, k < 3, $urandom_range(1, 6), $urandom_range(5, 40), -1);
    end
    check("tie_cnt", frame_cnt, 4);

    // Start timeout
    idle_cycles(2);
    do_timeout();
    check("timeout_cnt", frame_cnt, 4);

    // Random requesters
    for (int k = 0; k < 6; k++) begin
      bit a, b;
      a = 1'($urandom);
      b = 1'($urandom);
      if (!a && !b) b = 1'b1;
      rand_params();
      idle_cycles($urandom_range(0, 3));
      do_frame(a, b, 1'b0, $urandom_range(1, 6), $urandom_range(1, 60), -1);
    end

    // Data muxing with owner 1
    rand_params();
    da0 = 4'h3;
    da1 = 4'hA;
    do_frame(1'b0, 1'b1, 1'b0, 2, 20, -1);
    idle_cycles(2);

    // Reset mid-frame at nibble 40, then a tie must go to port 0
    rand_params();
    do_frame(1'b0, 1'b1, 1'b0, 2, 80, 40);
    rand_params();
    do_frame(1'b1, 1'b1, 1'b0, 2, 10, -1);
    check("post_rst_cnt", frame_cnt, 1);

    // Frame counter wrap
    idle_cycles(1);
    force dut.frame_cnt = 16'hFFFF;
    tick();
    release dut.frame_cnt;
    m_cnt = 16'hFFFF;
    sample();
    check("wrap_preload", frame_cnt, 16'hFFFF);
    rand_params();
    do_frame(1'b1, 1'b0, 1'b0, 2, 12, -1);
    check("wrap_cnt", frame_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
